// File: rtl/fifo_push_arbiter_if.sv
// Producer/FIFO-side signal bundle for fifo_push_arbiter.
// The slave modport is the arbiter's view; master is the producers and FIFO.
interface fifo_push_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned width = 16
);
   localparam int unsigned IdW = $clog2(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*width-1:0] req_data;
   logic [N_REQ-1:0]       req_ready;
   logic                   fifo_full;
   logic                   fifo_push;
   logic [width-1:0]       fifo_din;
   logic [IdW-1:0]         grant_id;
   logic                   busy;

   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_push, fifo_din, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_push, fifo_din, grant_id, busy
   );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers,
// with bounded bursts per owner. Define ARB_STATS_EN to add saturating grant_cnt counters.
module fifo_push_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned width     = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst,
   fifo_push_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0] grant_cnt
`endif
);
   localparam int unsigned     IdW    = $clog2(N_REQ);
   localparam int unsigned     CntW   = $clog2(MAX_BURST + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

   logic [IdW-1:0]  grant_q, last_q, sel, cand;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            busy_q, have_sel, accept;

   // Owner keeps the port while its quota lasts; otherwise search circularly after last_q.
   always_comb begin
      sel      = grant_q;
      cand     = '0;
      have_sel = 1'b0;
      if (busy_q && bus.req_valid[grant_q] && (cnt_q < MaxCnt)) begin
         have_sel = 1'b1;
      end else begin
         for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IdW'((32'(last_q) + k) % N_REQ);
            if (!have_sel && bus.req_valid[cand]) begin
               sel      = cand;
               have_sel = 1'b1;
            end
         end
      end
   end

   assign accept = rst && have_sel && !bus.fifo_full;
   assign cnt_d  = (busy_q && (sel == grant_q)) ? cnt_q + CntW'(1) : CntW'(1);

   always_comb begin
      bus.req_ready = '0;
      bus.fifo_push = 1'b0;
      bus.fifo_din  = '0;
      if (accept) begin
         bus.req_ready[sel] = 1'b1;
         bus.fifo_push      = 1'b1;
         bus.fifo_din       = bus.req_data[sel*width +: width];
      end
   end

   assign bus.grant_id = grant_q;
   assign bus.busy     = busy_q;

   // A full FIFO freezes all arbitration state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         grant_q <= '0;
         last_q  <= IdW'(N_REQ - 1);
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else if (!bus.fifo_full) begin
         if (have_sel) begin
            grant_q <= sel;
            last_q  <= sel;
            cnt_q   <= cnt_d;
            busy_q  <= (cnt_d < MaxCnt);
         end else begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
         end
      end
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         grant_cnt <= '0;
      end else if (accept && (grant_cnt[sel*16 +: 16] != 16'hFFFF)) begin
         grant_cnt[sel*16 +: 16] <= grant_cnt[sel*16 +: 16] + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: two instances (MAX_BURST 4 and 1) share stimulus and are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_fifo_push_arbiter;
   localparam int N     = 4;
   localparam int W     = 16;
   localparam int Depth = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req_valid;
   logic [N*W-1:0] req_data;
   logic         fifo_full;
   logic         fifo_mode;
   logic         pop;
   int           occ = 0;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   fifo_push_arbiter_if #(.N_REQ(N), .width(W)) ifa ();
   fifo_push_arbiter_if #(.N_REQ(N), .width(W)) ifr ();

   assign ifa.req_valid = req_valid;
   assign ifa.req_data  = req_data;
   assign ifa.fifo_full = fifo_full;
   assign ifr.req_valid = req_valid;
   assign ifr.req_data  = req_data;
   assign ifr.fifo_full = fifo_full;

   assign fifo_full = fifo_mode && (occ >= Depth);

`ifdef ARB_STATS_EN
   logic [N*16-1:0] gc_a, gc_r;
`endif

   fifo_push_arbiter #(.N_REQ(N), .width(W), .MAX_BURST(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
`ifdef ARB_STATS_EN
      ,
      .grant_cnt (gc_a)
`endif
   );

   fifo_push_arbiter #(.N_REQ(N), .width(W), .MAX_BURST(1)) dut_r (
      .clk (clk),
      .rst (rst),
      .bus (ifr)
`ifdef ARB_STATS_EN
      ,
      .grant_cnt (gc_r)
`endif
   );

   // FIFO occupancy seen by the arbiters; only dut_a's pushes fill it.
   always @(posedge clk) begin
      if (!rst) occ <= 0;
      else      occ <= occ + (ifa.fifo_push ? 1 : 0) - ((pop && occ > 0) ? 1 : 0);
   end

   logic [N-1:0] a_ready [2];
   logic         a_push  [2];
   logic [W-1:0] a_din   [2];
   logic [1:0]   a_grant [2];
   logic         a_busy  [2];
   assign a_ready[0] = ifa.req_ready;  assign a_ready[1] = ifr.req_ready;
   assign a_push[0]  = ifa.fifo_push;  assign a_push[1]  = ifr.fifo_push;
   assign a_din[0]   = ifa.fifo_din;   assign a_din[1]   = ifr.fifo_din;
   assign a_grant[0] = ifa.grant_id;   assign a_grant[1] = ifr.grant_id;
   assign a_busy[0]  = ifa.busy;       assign a_busy[1]  = ifr.busy;

   // Model state per instance (0: MAX_BURST=4, 1: MAX_BURST=1).
   int    mb [2] = '{4, 1};
   string nm [2] = '{"b4", "b1"};
   int    m_grant [2];
   int    m_busy  [2];
   int    m_cnt   [2];
   int    m_last  [2];
   int    m_gc    [2][N];
   int    t_sel;
   bit    t_have, t_acc;
   logic [N-1:0] e_ready;
   logic [W-1:0] e_din;

   int log_a[$];
   int log_r[$];
   int din_r[$];
   int busy_a[$];

   int e_rr_id  [5] = '{0, 1, 2, 3, 0};
   int e_rr_din [5] = '{'h0000, 'h1111, 'h2222, 'h3333, 'h0000};
   int e_b4_id  [5] = '{0, 0, 0, 0, 1};
   int e_burst  [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
   int e_drop   [7] = '{0, 0, 3, 3, 3, 3, 3};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lg(input int which, input int i);
      case (which)
         0:       return (i < log_a.size())  ? log_a[i]  : -1;
         1:       return (i < log_r.size())  ? log_r[i]  : -1;
         2:       return (i < din_r.size())  ? din_r[i]  : -1;
         default: return (i < busy_a.size()) ? busy_a[i] : -1;
      endcase
   endfunction

   task automatic model_reset(input int p);
      m_grant[p] = 0;
      m_busy[p]  = 0;
      m_cnt[p]   = 0;
      m_last[p]  = N - 1;
      for (int i = 0; i < N; i++) m_gc[p][i] = 0;
   endtask

   // Per-cycle compare against the model, then advance the model to the next edge.
   initial begin
      model_reset(0);
      model_reset(1);
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            t_have = 1'b0;
            t_sel  = 0;
            if (m_busy[p] != 0 && req_valid[m_grant[p]] && m_cnt[p] < mb[p]) begin
               t_have = 1'b1;
               t_sel  = m_grant[p];
            end else begin
               for (int k = 1; k <= N; k++) begin
                  if (!t_have && req_valid[(m_last[p] + k) % N]) begin
                     t_have = 1'b1;
                     t_sel  = (m_last[p] + k) % N;
                  end
               end
            end
            t_acc   = rst && t_have && !fifo_full;
            e_ready = t_acc ? N'(1 << t_sel) : '0;
            e_din   = t_acc ? req_data[t_sel*W +: W] : '0;
            chk({nm[p], ".req_ready"}, 32'(a_ready[p]), 32'(e_ready));
            chk({nm[p], ".fifo_push"}, 32'(a_push[p]), 32'(t_acc));
            chk({nm[p], ".fifo_din"}, 32'(a_din[p]), 32'(e_din));
            chk({nm[p], ".grant_id"}, 32'(a_grant[p]), m_grant[p]);
            chk({nm[p], ".busy"}, 32'(a_busy[p]), m_busy[p]);
`ifdef ARB_STATS_EN
            for (int i = 0; i < N; i++)
               chk({nm[p], ".grant_cnt"}, 32'(p == 0 ? gc_a[i*16 +: 16] : gc_r[i*16 +: 16]),
                   m_gc[p][i]);
`endif
            if (a_push[p]) begin
               for (int i = 0; i < N; i++) begin
                  if (a_ready[p][i]) begin
                     if (p == 0) log_a.push_back(i);
                     else        log_r.push_back(i);
                  end
               end
               if (p == 1) din_r.push_back(int'(a_din[p]));
            end
            if (p == 0) busy_a.push_back(int'(a_busy[p]));

            if (!rst) begin
               model_reset(p);
            end else if (!fifo_full) begin
               if (t_have) begin
                  m_cnt[p]   = (m_busy[p] != 0 && t_sel == m_grant[p]) ? m_cnt[p] + 1 : 1;
                  m_busy[p]  = (m_cnt[p] < mb[p]) ? 1 : 0;
                  m_grant[p] = t_sel;
                  m_last[p]  = t_sel;
                  if (m_gc[p][t_sel] < 65535) m_gc[p][t_sel]++;
               end else begin
                  m_busy[p] = 0;
                  m_cnt[p]  = 0;
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      log_a.delete();
      log_r.delete();
      din_r.delete();
      busy_a.delete();
   endtask

   task automatic pulse();
      rst       = 1'b0;
      req_valid = '0;
      cyc(1);
      rst = 1'b1;
      clr();
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      fifo_mode = 1'b0;
      pop       = 1'b0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(i * 32'h1111);

      // Reset held with every requester valid: nothing may be pushed.
      req_valid = 4'hF;
      cyc(3);
      chk("rst.push", 32'(ifa.fifo_push), 0);
      chk("rst.ready", 32'(ifa.req_ready), 0);
      rst = 1'b1;
      clr();
      #1;
      chk("rel.ready", 32'(ifa.req_ready), 32'h1);
      chk("rel.din", 32'(ifa.fifo_din), 32'h0);
      chk("rel.b1.ready", 32'(ifr.req_ready), 32'h1);

      // All four valid: pure round-robin on b1, burst of four on b4.
      cyc(5);
      chk("rr.len", log_r.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk("rr.id", lg(1, i), e_rr_id[i]);
         chk("rr.din", lg(2, i), e_rr_din[i]);
         chk("b4.id", lg(0, i), e_b4_id[i]);
      end

      // Requesters 1 and 2: bursts of four alternate.
      pulse();
      req_valid = 4'b0110;
      cyc(9);
      chk("burst.len", log_a.size(), 9);
      for (int i = 0; i < 9; i++) chk("burst.id", lg(0, i), e_burst[i]);
      chk("burst.busy3", lg(3, 3), 1);
      chk("burst.busy4", lg(3, 4), 0);
      chk("burst.busy8", lg(3, 8), 0);
      for (int i = 0; i < 4; i++) chk("burst.b1.id", lg(1, i), 1 + (i % 2));

      // Fill an 8-deep FIFO from requester 0, then release one slot.
      pulse();
      fifo_mode = 1'b1;
      req_valid = 4'b0001;
      cyc(10);
      chk("bp.len", log_a.size(), Depth);
      chk("bp.ready", 32'(ifa.req_ready), 0);
      chk("bp.push", 32'(ifa.fifo_push), 0);
      pop = 1'b1;
      cyc(1);
      pop = 1'b0;
      cyc(3);
      chk("bp.len2", log_a.size(), Depth + 1);
      chk("bp.grant", 32'(ifa.grant_id), 0);
      fifo_mode = 1'b0;

      // Owner 0 drops valid mid-burst; requester 3 takes over in the same cycle.
      pulse();
      req_valid = 4'b1001;
      cyc(2);
      req_valid = 4'b1000;
      #1;
      chk("drop.ready", 32'(ifa.req_ready), 32'h8);
      cyc(5);
      chk("drop.len", log_a.size(), 7);
      for (int i = 0; i < 7; i++) chk("drop.id", lg(0, i), e_drop[i]);
      chk("drop.busy5", lg(3, 5), 1);
      chk("drop.busy6", lg(3, 6), 0);

`ifdef ARB_STATS_EN
      pulse();
      req_valid = 4'b0100;
      cyc(10);
      req_valid = 4'b0001;
      cyc(3);
      req_valid = '0;
      #1;
      chk("gc.a2", 32'(gc_a[2*16 +: 16]), 10);
      chk("gc.a0", 32'(gc_a[0 +: 16]), 3);
      chk("gc.r2", 32'(gc_r[2*16 +: 16]), 10);
      chk("gc.r0", 32'(gc_r[0 +: 16]), 3);
      pulse();
      #1;
      chk("gc.clr", 32'(gc_a == '0), 1);
`endif

      req_valid = '0;
      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
